// File: rtl/register_file.sv
// 32 x 32-bit MIPS-style register file: two combinational read ports and one
// write port that stores on every rising clock edge. Register 0 reads as zero.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_w_data,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];

    logic w_rs_zero;
    logic w_rt_zero;
    logic w_wr_en;

    // No write enable: the write port stores every edge unless it targets r0.
    assign w_wr_en = (rd_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rd_addr] <= rd_w_data;
        end
    end

    // Gating with rst keeps the outputs at zero while reset is held, even
    // before the first clearing edge has landed.
    assign w_rs_zero = rst || (rs_addr == '0);
    assign w_rt_zero = rst || (rt_addr == '0);

    assign rs_data = w_rs_zero ? '0 : r_regs[rs_addr];
    assign rt_data = w_rt_zero ? '0 : r_regs[rt_addr];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: expected read values are queued as
// stimulus is applied and popped when the combinational outputs are sampled.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_w_data;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    logic [DATA_W-1:0] model [32];
    logic [DATA_W-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .rd_w_data (rd_w_data),
        .rs_data   (rs_data),
        .rt_data   (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver only: one write on the next rising edge, then park rd_addr at r0.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rd_addr   = a;
        rd_w_data = d;
        @(posedge clk);
        if (a != 0) model[a] = d;
        #1;
        rd_addr = '0;
    endtask

    task automatic test_reset;
        logic [DATA_W-1:0] e;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rs_addr = 5'd9;
        rt_addr = 5'd31;
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL reset_hold_rs: got %h expected %h", rs_data, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rt_data !== e) begin n_fail++; $display("FAIL reset_hold_rt: got %h expected %h", rt_data, e); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = ADDR_W'(i);
            rt_addr = ADDR_W'(31 - i);
            exp_q.push_back('0);
            exp_q.push_back('0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rs_data !== e) begin n_fail++; $display("FAIL reset_sweep_rs[%0d]: got %h expected %h", i, rs_data, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rt_data !== e) begin n_fail++; $display("FAIL reset_sweep_rt[%0d]: got %h expected %h", 31 - i, rt_data, e); end
        end
    endtask

    task automatic test_write_readback;
        logic [DATA_W-1:0] e;
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        rs_addr = 5'd5;
        rt_addr = 5'd31;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL readback_r5: got %h expected %h", rs_data, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rt_data !== e) begin n_fail++; $display("FAIL readback_r31: got %h expected %h", rt_data, e); end
        rs_addr = 5'd31;
        rt_addr = 5'd5;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL readback_swap_rs: got %h expected %h", rs_data, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rt_data !== e) begin n_fail++; $display("FAIL readback_swap_rt: got %h expected %h", rt_data, e); end
    endtask

    task automatic test_r0_protect;
        logic [DATA_W-1:0] e;
        do_write(5'd0, 32'hFFFFFFFF);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL r0_protect_rs: got %h expected %h", rs_data, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rt_data !== e) begin n_fail++; $display("FAIL r0_protect_rt: got %h expected %h", rt_data, e); end
    endtask

    task automatic test_same_cycle;
        logic [DATA_W-1:0] e;
        do_write(5'd7, 32'h11);
        @(negedge clk);
        rd_addr   = 5'd7;
        rd_w_data = 32'h22;
        rs_addr   = 5'd7;
        rt_addr   = 5'd7;
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h11);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL same_cycle_pre_rs: got %h expected %h", rs_data, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rt_data !== e) begin n_fail++; $display("FAIL same_cycle_pre_rt: got %h expected %h", rt_data, e); end
        @(posedge clk);
        model[7] = 32'h22;
        exp_q.push_back(32'h22);
        #1;
        rd_addr = '0;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL same_cycle_post_rs: got %h expected %h", rs_data, e); end
    endtask

    task automatic test_back_to_back;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            rd_addr   = ADDR_W'(i + 10);
            rd_w_data = 32'hA5A50000 + 32'(i);
            @(posedge clk);
            model[i + 10] = 32'hA5A50000 + 32'(i);
            #1;
        end
        rd_addr = '0;
        for (int i = 1; i <= 4; i++) begin
            rs_addr = ADDR_W'(i + 10);
            rt_addr = ADDR_W'(i + 10);
            exp_q.push_back(32'hA5A50000 + 32'(i));
            exp_q.push_back(32'hA5A50000 + 32'(i));
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rs_data !== e) begin n_fail++; $display("FAIL b2b_rs[%0d]: got %h expected %h", i + 10, rs_data, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rt_data !== e) begin n_fail++; $display("FAIL b2b_rt[%0d]: got %h expected %h", i + 10, rt_data, e); end
        end
    endtask

    task automatic test_reset_over_write;
        logic [DATA_W-1:0] e;
        do_write(5'd3, 32'h55);
        @(negedge clk);
        rst       = 1'b1;
        rd_addr   = 5'd3;
        rd_w_data = 32'hAA;
        rs_addr   = 5'd5;
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL reset_gates_read: got %h expected %h", rs_data, e); end
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1;
        rst     = 1'b0;
        rd_addr = '0;
        rs_addr = 5'd3;
        rt_addr = 5'd5;
        exp_q.push_back(model[3]);
        exp_q.push_back(model[5]);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (rs_data !== e) begin n_fail++; $display("FAIL reset_over_write_r3: got %h expected %h", rs_data, e); end
        e = exp_q.pop_front(); n_checks++;
        if (rt_data !== e) begin n_fail++; $display("FAIL reset_over_write_r5: got %h expected %h", rt_data, e); end
        for (int k = 0; k < 8; k++) do_write(ADDR_W'($urandom_range(1, 31)), $urandom | 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = ADDR_W'(i);
            rt_addr = ADDR_W'(i ^ 5'h1F);
            exp_q.push_back('0);
            exp_q.push_back('0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rs_data !== e) begin n_fail++; $display("FAIL midrun_reset_rs[%0d]: got %h expected %h", i, rs_data, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rt_data !== e) begin n_fail++; $display("FAIL midrun_reset_rt[%0d]: got %h expected %h", i ^ 31, rt_data, e); end
        end
    endtask

    task automatic test_random;
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a, b, w;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a = ADDR_W'($urandom_range(0, 31));
            b = ADDR_W'($urandom_range(0, 31));
            w = ADDR_W'($urandom_range(0, 31));
            d = $urandom;
            rs_addr   = a;
            rt_addr   = b;
            rd_addr   = w;
            rd_w_data = d;
            exp_q.push_back(model[a]);
            exp_q.push_back(model[b]);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rs_data !== e) begin n_fail++; $display("FAIL random_rs[%0d] addr %0d: got %h expected %h", k, a, rs_data, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rt_data !== e) begin n_fail++; $display("FAIL random_rt[%0d] addr %0d: got %h expected %h", k, b, rt_data, e); end
            @(posedge clk);
            if (w != 0) model[w] = d;
            #1;
            rs_addr = w;
            rt_addr = 5'd0;
            exp_q.push_back(model[w]);
            exp_q.push_back('0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (rs_data !== e) begin n_fail++; $display("FAIL random_wr[%0d] addr %0d: got %h expected %h", k, w, rs_data, e); end
            e = exp_q.pop_front(); n_checks++;
            if (rt_data !== e) begin n_fail++; $display("FAIL random_r0[%0d]: got %h expected %h", k, rt_data, e); end
        end
        rd_addr = '0;
    endtask

    initial begin
        rst       = 1'b1;
        rs_addr   = '0;
        rt_addr   = '0;
        rd_addr   = '0;
        rd_w_data = '0;
        test_reset();
        test_write_readback();
        test_r0_protect();
        test_same_cycle();
        test_back_to_back();
        test_reset_over_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
